// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  // One extra bit so the counter can represent DATA_W itself.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_DATA_W);

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration on {rem, dividend}.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] dividend_next,
  output logic              quo_bit
);

  logic [DATA_W:0] shifted;

  // rem < divisor on entry, so the restored value always fits DATA_W bits
  // and the low-bit subtraction equals the full-width one.
  always_comb begin
    shifted       = {rem, dividend[DATA_W-1]};
    quo_bit       = (shifted >= {1'b0, divisor});
    rem_next      = quo_bit ? (shifted[DATA_W-1:0] - divisor) : shifted[DATA_W-1:0];
    dividend_next = dividend << 1;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// SEQ_DIVIDER_DIVZERO_EN adds o_div_zero and a one-cycle b==0 shortcut.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_value_a,
  input  logic [DATA_W-1:0] i_value_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_value_quo,
  output logic [DATA_W-1:0] o_value_rem
`ifdef SEQ_DIVIDER_DIVZERO_EN
  ,
  output logic              o_div_zero
`endif
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  state_t            state;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem_out;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_dividend;
  logic              step_quo_bit;
  logic [DATA_W-1:0] next_dividend;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem           (rem),
    .dividend      (dividend),
    .divisor       (divisor),
    .rem_next      (step_rem),
    .dividend_next (step_dividend),
    .quo_bit       (step_quo_bit)
  );

  // Quotient bits fill the dividend register from the bottom as it drains.
  assign next_dividend = step_dividend | DATA_W'(step_quo_bit);

`ifdef SEQ_DIVIDER_DIVZERO_EN
  logic div_zero;
  assign o_div_zero = div_zero;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      quo      <= '0;
      rem_out  <= '0;
      rem      <= '0;
      dividend <= '0;
      divisor  <= '0;
      cnt      <= '0;
`ifdef SEQ_DIVIDER_DIVZERO_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            dividend <= i_value_a;
            divisor  <= i_value_b;
            rem      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
`ifdef SEQ_DIVIDER_DIVZERO_EN
            if (i_value_b == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              quo      <= '1;
              rem_out  <= i_value_a;
              div_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          rem      <= step_rem;
          dividend <= next_dividend;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state   <= DONE;
            done    <= 1'b1;
            quo     <= next_dividend;
            rem_out <= step_rem;
`ifdef SEQ_DIVIDER_DIVZERO_EN
            div_zero <= 1'b0;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = busy;
  assign o_done      = done;
  assign o_value_quo = quo;
  assign o_value_rem = rem_out;

endmodule
